pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 6-stage MIPS core (PC, IF, ID, EX, MEM, WB). It merges per-stage stall requests into the 6-bit stall vector consumed by every pipeline register. It converts MEM-stage exception/ERET status into the single-cycle flush pulse and redirect PC. It also keeps a stall-cycle performance counter and a stall-deadlock watchdog.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect PC for any exception (BEV=1 general vector).
WDT_LIMIT, 1024, consecutive stalled cycles before the watchdog trips (>=2).
CNT_W, 32, width of stall-cycle counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
stallreq_if  in  1  IF (icache miss) stall request.
stallreq_id  in  1  ID (load-use / branch operand) stall request.
stallreq_ex  in  1  EX (mult/div busy) stall request.
stallreq_mem  in  1  MEM (dcache/uncached access) stall request.
i_except  in  7  MEM-stage exception vector; nonzero = exception.
i_eret  in  1  MEM-stage ERET.
i_cp0_epc  in  32  current CP0 EPC (bypassed value).
stall  out  6  bit0 PC … bit5 WB; 1 = Stop.
flush  out  1  flush all pipeline registers this cycle.
o_new_pc  out  32  redirect target, valid when flush=1.
o_stall_cnt  out  CNT_W  total cycles with stall!=0.
o_wdt_err  out  1  sticky watchdog error (only with the optional feature).

Behaviour:
- Reset: state=RUN, stall=0, flush=0, o_new_pc=0, o_stall_cnt=0, run-length counter=0, o_wdt_err=0.
- Stall priority, combinational:
  - stallreq_mem -> 6'b011111
  - else stallreq_ex -> 6'b001111
  - else stallreq_id -> 6'b000111
  - else stallreq_if -> 6'b000011
  - else 0.
  - Consequence: the stage just past the highest stalled stage sees Stop/NoStop and inserts a bubble.
- Exception take condition (evt): (i_except!=0 or i_eret) and stallreq_mem==0 and state!=FLUSH.
  - While stallreq_mem=1, the exception is held, not taken.
- On evt, same cycle (combinational):
  - flush=1, stall=0 (flush overrides all stall requests).
  - o_new_pc = EXC_VECTOR if i_except!=0 (exception beats simultaneous ERET), else i_cp0_epc.
- o_new_pc is additionally registered and holds its last value when flush=0.
- FSM:
  - RUN: evt -> FLUSH; else stall!=0 -> STALL.
  - STALL: evt -> FLUSH; stall==0 -> RUN.
  - FLUSH: lasts exactly 1 cycle, then -> RUN (or STALL if stall!=0 that cycle).
  - In FLUSH, evt is masked, so stale exception bits cannot cause a second flush. Stall requests are honoured normally in FLUSH.
- Run-length counter:
  - Increments each cycle stall!=0; clears on any cycle stall==0 or on flush.
  - Saturates at WDT_LIMIT.
- o_stall_cnt: +1 every cycle stall!=0; wraps modulo 2^CNT_W; not cleared by flush.
- Reset asserted mid-stall or in FLUSH: next cycle all outputs are at reset values. No pending exception is remembered.

Optional Feature:
PIPE_CTRL_WDT_EN.
- Defined: when the run-length counter reaches WDT_LIMIT, o_wdt_err sets the next cycle and stays 1 until reset. Stall behaviour is unchanged.
- Undefined: no watchdog logic; o_wdt_err tied 0.

Test Plan:
1. Reset, then stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111; release both -> stall=0 next comb eval; o_stall_cnt=1 per stalled cycle.
2. stallreq_if, id, ex, mem all 1 -> stall=6'b011111; drop mem only -> 6'b001111.
3. i_except=7'h04 with stallreq_ex=1 -> same cycle flush=1, stall=0, o_new_pc=32'hBFC00380. Next cycle state FLUSH; i_except still nonzero -> flush=0.
4. i_eret=1, i_cp0_epc=32'h80001234 -> flush=1, o_new_pc=32'h80001234. With i_except=7'h01 also set -> o_new_pc=32'hBFC00380.
5. i_except=7'h10 while stallreq_mem=1 for 3 cycles -> flush=0, stall=6'b011111. Cycle stallreq_mem drops -> flush=1.
6. With PIPE_CTRL_WDT_EN, WDT_LIMIT=8: stallreq_mem high 8 cycles -> o_wdt_err=1 after 8th and stays 1 after release. Without the macro -> o_wdt_err=0 throughout.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, exception flush/redirect, stall counter, optional watchdog (PIPE_CTRL_WDT_EN)
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int WDT_LIMIT = 1024,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [6:0]       i_except,
  input  logic             i_eret,
  input  logic [31:0]      i_cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      o_new_pc,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_wdt_err
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t state_q, state_d;
  logic evt;
  logic [5:0] req;
  logic [31:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q;
  // stall priority, exception take and redirect selection
  always_comb begin
    req = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
          stallreq_id ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    evt = (|i_except || i_eret) && !stallreq_mem && state_q != FLUSH;
    stall = evt ? 6'b000000 : req;
    flush = evt;
    pc_d = evt ? (|i_except ? EXC_VECTOR : i_cp0_epc) : pc_q;
    o_new_pc = pc_d;
    state_d = evt ? FLUSH : |stall ? STALL : RUN;
  end
  // state, held redirect target and stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_q + CNT_W'(|stall);
    end
  end
  assign o_stall_cnt = cnt_q;
`ifdef PIPE_CTRL_WDT_EN
  localparam int RW = $clog2(WDT_LIMIT + 1);
  logic [RW-1:0] run_q, run_d;
  logic wdt_q;
  // consecutive-stall run length, saturating at the limit
  always_comb begin
    run_d = !(|stall) ? '0 : run_q == RW'(WDT_LIMIT) ? run_q : run_q + 1'b1;
  end
  // sticky watchdog flag once the run length hits the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= '0;
      wdt_q <= 1'b0;
    end else begin
      run_q <= run_d;
      wdt_q <= wdt_q | (run_d == RW'(WDT_LIMIT));
    end
  end
  assign o_wdt_err = wdt_q;
`else
  assign o_wdt_err = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven check of pipe_ctrl plus watchdog sequences
module tb_pipe_ctrl;
`ifdef PIPE_CTRL_WDT_EN
  localparam logic WDT = 1'b1;
`else
  localparam logic WDT = 1'b0;
`endif
  localparam logic [31:0] EV = 32'hBFC00380;
  logic clk = 1'b0, reset = 1'b1;
  logic sif = 1'b0, sid = 1'b0, sex = 1'b0, smem = 1'b0, eret = 1'b0;
  logic [6:0] exc = '0;
  logic [31:0] epc = '0;
  logic [5:0] stall;
  logic flush, wdt;
  logic [31:0] npc, cnt;
  int nvec = 0, nerr = 0;

  pipe_ctrl #(.WDT_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .stallreq_if(sif), .stallreq_id(sid),
    .stallreq_ex(sex), .stallreq_mem(smem), .i_except(exc), .i_eret(eret),
    .i_cp0_epc(epc), .stall(stall), .flush(flush), .o_new_pc(npc),
    .o_stall_cnt(cnt), .o_wdt_err(wdt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, mem, ex, id, ifs;
    logic [6:0] exc;
    logic eret;
    logic [31:0] epc;
    logic [5:0] stall;
    logic flush;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t v[29];

  function automatic vec_t mk(logic rst, logic mem, logic ex, logic id, logic ifs,
                              logic [6:0] e, logic er, logic [31:0] ep,
                              logic [5:0] st, logic fl, logic [31:0] pc, logic [31:0] c);
    vec_t r;
    r.rst = rst; r.mem = mem; r.ex = ex; r.id = id; r.ifs = ifs;
    r.exc = e; r.eret = er; r.epc = ep;
    r.stall = st; r.flush = fl; r.pc = pc; r.cnt = c;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(logic r, logic m, logic x, logic d, logic f, logic [6:0] e, logic er, logic [31:0] ep);
    @(negedge clk);
    reset = r; smem = m; sex = x; sid = d; sif = f; exc = e; eret = er; epc = ep;
    #1;
  endtask

  initial begin
    v[0]  = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,0,0);
    v[1]  = mk(0,0,1,1,0, 7'h00,0,0,            6'b001111,0,0,0);
    v[2]  = mk(0,0,1,1,0, 7'h00,0,0,            6'b001111,0,0,1);
    v[3]  = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,0,2);
    v[4]  = mk(0,1,1,1,1, 7'h00,0,0,            6'b011111,0,0,2);
    v[5]  = mk(0,0,1,1,1, 7'h00,0,0,            6'b001111,0,0,3);
    v[6]  = mk(0,0,0,0,1, 7'h00,0,0,            6'b000011,0,0,4);
    v[7]  = mk(0,0,0,1,0, 7'h00,0,0,            6'b000111,0,0,5);
    v[8]  = mk(0,0,1,0,0, 7'h04,0,0,            6'b000000,1,EV,6);
    v[9]  = mk(0,0,1,0,0, 7'h04,0,0,            6'b001111,0,EV,6);
    v[10] = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,EV,7);
    v[11] = mk(0,0,0,0,0, 7'h00,1,32'h80001234, 6'b000000,1,32'h80001234,7);
    v[12] = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,32'h80001234,7);
    v[13] = mk(0,0,0,0,0, 7'h01,1,32'h80001234, 6'b000000,1,EV,7);
    v[14] = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,EV,7);
    v[15] = mk(0,1,0,0,0, 7'h10,0,0,            6'b011111,0,EV,7);
    v[16] = mk(0,1,0,0,0, 7'h10,0,0,            6'b011111,0,EV,8);
    v[17] = mk(0,1,0,0,0, 7'h10,0,0,            6'b011111,0,EV,9);
    v[18] = mk(0,0,0,0,0, 7'h10,0,0,            6'b000000,1,EV,10);
    v[19] = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,EV,10);
    v[20] = mk(0,0,0,0,0, 7'h00,1,32'h12345678, 6'b000000,1,32'h12345678,10);
    v[21] = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,32'h12345678,10);
    v[22] = mk(0,1,0,0,0, 7'h00,0,0,            6'b011111,0,32'h12345678,10);
    v[23] = mk(1,1,0,0,0, 7'h00,0,0,            6'b011111,0,32'h12345678,11);
    v[24] = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,0,0);
    v[25] = mk(0,0,0,0,0, 7'h02,0,0,            6'b000000,1,EV,0);
    v[26] = mk(1,0,0,0,0, 7'h00,0,0,            6'b000000,0,EV,0);
    v[27] = mk(0,0,0,0,0, 7'h00,0,0,            6'b000000,0,0,0);
    v[28] = mk(0,0,0,0,0, 7'h02,0,0,            6'b000000,1,EV,0);
    drive(1,0,0,0,0,0,0,0);
    drive(1,0,0,0,0,0,0,0);
    for (int i = 0; i < 29; i++) begin
      drive(v[i].rst, v[i].mem, v[i].ex, v[i].id, v[i].ifs, v[i].exc, v[i].eret, v[i].epc);
      nvec++;
      if (stall !== v[i].stall || flush !== v[i].flush || npc !== v[i].pc || cnt !== v[i].cnt || wdt !== 1'b0) begin
        nerr++;
        $display("FAIL vec%0d: got stall=%b flush=%b pc=%h cnt=%0d wdt=%b expected stall=%b flush=%b pc=%h cnt=%0d wdt=0",
                 i, stall, flush, npc, cnt, wdt, v[i].stall, v[i].flush, v[i].pc, v[i].cnt);
      end
    end
    drive(1,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    chk("wdt_after_reset", {31'd0, wdt}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(0,1,0,0,0,0,0,0);
      chk("wdt_pre_limit", {31'd0, wdt}, 32'd0);
    end
    drive(0,0,0,0,0,0,0,0);
    chk("wdt_trip", {31'd0, wdt}, {31'd0, WDT});
    chk("wdt_cnt", cnt, 32'd8);
    drive(0,0,0,0,0,0,0,0);
    chk("wdt_sticky", {31'd0, wdt}, {31'd0, WDT});
    drive(1,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    chk("wdt_reset_clear", {31'd0, wdt}, 32'd0);
    for (int i = 0; i < 7; i++) drive(0,0,1,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    for (int i = 0; i < 7; i++) drive(0,0,0,1,0,0,0,0);
    drive(0,0,0,0,0,0,0,0);
    chk("wdt_broken_runs", {31'd0, wdt}, 32'd0);
    chk("cnt_broken_runs", cnt, 32'd14);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
